// File: rtl/divider_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH + 1);
  localparam logic [DIV_WIDTH-1:0] DZ_QUO = '1;

endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring shift-and-subtract iteration, using invert-and-carry-in subtraction.
module div_step
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sh    = {rem, quo[WIDTH-1]};
    // trial bit WIDTH is the sign: set means the subtraction borrowed
    trial = sh + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    if (trial[WIDTH]) begin
      rem_nxt = sh[WIDTH-1:0];
    end else begin
      rem_nxt = trial[WIDTH-1:0];
    end
    quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider with start/busy/done handshake, one quotient bit per clock.
// Signed support is built only when SIGNED_DIV_EN is defined.
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] DZ_Q = (WIDTH == DIV_WIDTH) ? WIDTH'(DZ_QUO) : {WIDTH{1'b1}};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            accept, step, fin;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic             dz_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef SIGNED_DIV_EN
  logic dvd_neg, dvs_neg;
  logic dvd_neg_q, dvs_neg_q;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_neg_q <= dvd_neg;
      dvs_neg_q <= dvs_neg;
    end
  end

  // MIN / -1 needs no special case: magnitude 2^(W-1) negates back to MIN
  assign quo_fix = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
  assign rem_fix = dvd_neg_q ? -rem_q : rem_q;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quo_fix = quo_q;
  assign rem_fix = rem_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (divisor == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working datapath registers carry no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q <= '0;
      quo_q <= dvd_mag;
      dvs_q <= dvs_mag;
      dvd_q <= dividend;
      dz_q  <= (divisor == '0);
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= fin;
      if (accept) begin
        cnt_q <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (accept) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (fin) begin
        div_by_zero <= dz_q;
        quotient    <= dz_q ? DZ_Q : quo_fix;
        remainder   <= dz_q ? dvd_q : rem_fix;
      end
    end
  end

endmodule
